hit_event_detector: RTL and testbench

- Sits directly upstream of the score/7-segment display and consumes the per-pixel draw requests from the sprite objects.
- Detects missile-vs-monster and bomb-vs-player overlaps during the raster scan.
- Reduces each overlap to exactly one registered event pulse per frame boundary: monsterHit feeds the score display, playerHit feeds lives logic.
- Also reports the raster position of the first monster overlap so the monster matrix can delete the hit monster.

---
 rtl/hit_pkg.sv | 25 ++
 rtl/hit_channel.sv | 117 +++++++++++
 rtl/hit_event_detector.sv | 93 +++++++++
 tb/tb_hit_event_detector.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hit_pkg.sv
// Shared types and defaults for the hit event detector.
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshakes in this block).
package hit_pkg;

    // Raster coordinate width.
    localparam int COORD_W_DEF = 11;

    // Cooldown counter width. It must hold the larger of the two cooldowns.
    localparam int CNT_W_DEF = 6;

    // Frames to ignore monster overlaps after a report, while the hit sprite is removed.
    localparam int MONSTER_COOLDOWN_DEF = 2;

    // Frames of player invulnerability after a playerHit.
    localparam int PLAYER_COOLDOWN_DEF = 60;

    // Per-channel detection state.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DETECTED = 2'd1,
        COOLDOWN = 2'd2
    } chan_state_t;

endpackage

// File: rtl/hit_channel.sv
// One overlap channel: latches an overlap and reports it once at the next frame boundary.
// Latency: startOfFrame at cycle N gives hitPulse in cycle N+1. report is the same event one cycle earlier (combinational).
// Backpressure: none. Overlaps during DETECTED or COOLDOWN are dropped, so one frame yields at most one event.
module hit_channel
    import hit_pkg::*;
#(
    parameter int COORD_W         = COORD_W_DEF,
    parameter int CNT_W           = CNT_W_DEF,
    parameter int COOLDOWN_FRAMES = 0,
    parameter bit CAPTURE_EN      = 1'b0
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic               overlap,
    input  logic [COORD_W-1:0] pixelX,
    input  logic [COORD_W-1:0] pixelY,
    output logic               report,
    output logic               hitPulse,
    output logic [COORD_W-1:0] capX,
    output logic [COORD_W-1:0] capY
);

    localparam logic [CNT_W-1:0] COOL_LD = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    chan_state_t      state;
    chan_state_t      stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic             pulseNext;
    logic             capLoad;

    // An overlap on the startOfFrame pixel belongs to the new frame. A channel
    // that would be idle in that frame enters DETECTED straight away. A channel
    // still cooling down ignores the overlap.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        pulseNext = 1'b0;
        capLoad   = 1'b0;
        if (!enable) begin
            stateNext = IDLE;
            cntNext   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (overlap) begin
                        stateNext = DETECTED;
                        capLoad   = 1'b1;
                    end
                end
                DETECTED: begin
                    if (startOfFrame) begin
                        pulseNext = 1'b1;
                        cntNext   = COOL_LD;
                        if (COOL_LD != '0) begin
                            stateNext = COOLDOWN;
                        end else if (overlap) begin
                            stateNext = DETECTED;
                            capLoad   = 1'b1;
                        end else begin
                            stateNext = IDLE;
                        end
                    end
                end
                COOLDOWN: begin
                    if (startOfFrame) begin
                        if (cnt > CNT_ONE) begin
                            cntNext = cnt - CNT_ONE;
                        end else begin
                            cntNext = '0;
                            if (overlap) begin
                                stateNext = DETECTED;
                                capLoad   = 1'b1;
                            end else begin
                                stateNext = IDLE;
                            end
                        end
                    end
                end
                default: begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end
            endcase
        end
    end

    // State, cooldown counter and registered event pulse.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            cnt      <= '0;
            hitPulse <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            hitPulse <= pulseNext;
        end
    end

    // Capture the position of the first overlap of the frame. Only the channel built with CAPTURE_EN captures.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            capX <= '0;
            capY <= '0;
        end else if (CAPTURE_EN && capLoad) begin
            capX <= pixelX;
            capY <= pixelY;
        end
    end

    assign report = pulseNext;

endmodule

// File: rtl/hit_event_detector.sv
// Turns missile/monster and bomb/player draw overlaps into one event pulse per frame boundary, and reports where the first monster hit was.
// Latency: startOfFrame at cycle N gives monsterHit/playerHit and the updated hitX/hitY in cycle N+1.
// Backpressure: none. There is no event queue, so repeated overlaps within a frame collapse into one pulse.
module hit_event_detector
    import hit_pkg::*;
#(
    parameter int COORD_W                 = COORD_W_DEF,
    parameter int MONSTER_COOLDOWN_FRAMES = MONSTER_COOLDOWN_DEF,
    parameter int PLAYER_COOLDOWN_FRAMES  = PLAYER_COOLDOWN_DEF,
    parameter int CNT_W                   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic [COORD_W-1:0] pixelX,
    input  logic [COORD_W-1:0] pixelY,
    input  logic               missileDR,
    input  logic               monstersDR,
    input  logic               bombDR,
    input  logic               playerDR,
    output logic               monsterHit,
    output logic               playerHit,
    output logic [COORD_W-1:0] hitX,
    output logic [COORD_W-1:0] hitY
);

    logic               monsterOverlap;
    logic               playerOverlap;
    logic               monsterReport;
    logic [COORD_W-1:0] monsterCapX;
    logic [COORD_W-1:0] monsterCapY;
    logic               playerReport;
    logic [COORD_W-1:0] playerCapX;
    logic [COORD_W-1:0] playerCapY;
    logic               unusedPlayer;

    assign monsterOverlap = missileDR & monstersDR;
    assign playerOverlap  = bombDR & playerDR;

    hit_channel #(
        .COORD_W        (COORD_W),
        .CNT_W          (CNT_W),
        .COOLDOWN_FRAMES(MONSTER_COOLDOWN_FRAMES),
        .CAPTURE_EN     (1'b1)
    ) monsterChannel (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .enable      (enable),
        .overlap     (monsterOverlap),
        .pixelX      (pixelX),
        .pixelY      (pixelY),
        .report      (monsterReport),
        .hitPulse    (monsterHit),
        .capX        (monsterCapX),
        .capY        (monsterCapY)
    );

    hit_channel #(
        .COORD_W        (COORD_W),
        .CNT_W          (CNT_W),
        .COOLDOWN_FRAMES(PLAYER_COOLDOWN_FRAMES),
        .CAPTURE_EN     (1'b0)
    ) playerChannel (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .enable      (enable),
        .overlap     (playerOverlap),
        .pixelX      (pixelX),
        .pixelY      (pixelY),
        .report      (playerReport),
        .hitPulse    (playerHit),
        .capX        (playerCapX),
        .capY        (playerCapY)
    );

    // The player channel has no coordinate path. Its report strobe and capture outputs are deliberately left unused.
    assign unusedPlayer = ^{playerReport, playerCapX, playerCapY};

    // Publish the captured coordinates on the same edge that raises monsterHit. They hold until the next report.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hitX <= '0;
            hitY <= '0;
        end else if (monsterReport) begin
            hitX <= monsterCapX;
            hitY <= monsterCapY;
        end
    end

endmodule

// File: tb/tb_hit_event_detector.sv
module tb_hit_event_detector;

    localparam int MCOOL = 2;
    localparam int PCOOL = 60;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        enable;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        missileDR;
    logic        monstersDR;
    logic        bombDR;
    logic        playerDR;
    logic        monsterHit;
    logic        playerHit;
    logic [10:0] hitX;
    logic [10:0] hitY;

    int checks   = 0;
    int failures = 0;

    hit_event_detector dut (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .enable      (enable),
        .pixelX      (pixelX),
        .pixelY      (pixelY),
        .missileDR   (missileDR),
        .monstersDR  (monstersDR),
        .bombDR      (bombDR),
        .playerDR    (playerDR),
        .monsterHit  (monsterHit),
        .playerHit   (playerHit),
        .hitX        (hitX),
        .hitY        (hitY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic sof;
        logic en;
        logic mis;
        logic mon;
        logic bmb;
        logic ply;
        int   x;
        int   y;
        logic emh;
        logic eph;
        int   ehx;
        int   ehy;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state: pending event, frames still to skip, first position.
    bit mPend, pPend;
    int mBlk, pBlk, mFx, mFy;
    bit expMh, expPh;
    int expHx, expHy;

    function automatic void addv(logic sof, logic en, logic mis, logic mon, logic bmb, logic ply,
                                 int x, int y, logic emh, logic eph, int ehx, int ehy);
        vec_t v;
        v = '{sof, en, mis, mon, bmb, ply, x, y, emh, eph, ehx, ehy};
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic emh, input logic eph, input int ehx, input int ehy);
        chk({tag, ".monsterHit"}, {31'd0, monsterHit}, {31'd0, emh});
        chk({tag, ".playerHit"},  {31'd0, playerHit},  {31'd0, eph});
        chk({tag, ".hitX"},       {21'd0, hitX},       ehx);
        chk({tag, ".hitY"},       {21'd0, hitY},       ehy);
    endtask

    task automatic drive(input logic sof, input logic en, input logic mis, input logic mon,
                         input logic bmb, input logic ply, input int x, input int y);
        startOfFrame = sof;
        enable       = en;
        missileDR    = mis;
        monstersDR   = mon;
        bombDR       = bmb;
        playerDR     = ply;
        pixelX       = x[10:0];
        pixelY       = y[10:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit check);
        resetN = 1'b0;
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        if (check) chk_all("reset", 0, 0, 0, 0);
        resetN = 1'b1;
        mPend = 0; pPend = 0; mBlk = 0; pBlk = 0; mFx = 0; mFy = 0;
        expMh = 0; expPh = 0; expHx = 0; expHy = 0;
    endtask

    // Frame-level reference: an overlap arms a channel unless that channel still has frames to skip. The boundary reports it and starts the skip count.
    task automatic model_step(input bit sof, input bit en, input bit mov, input bit pov, input int x, input int y);
        expMh = 0;
        expPh = 0;
        if (!en) begin
            mPend = 0; pPend = 0; mBlk = 0; pBlk = 0;
        end else begin
            if (sof) begin
                if (mPend) begin
                    expMh = 1; expHx = mFx; expHy = mFy; mBlk = MCOOL;
                end else if (mBlk > 0) begin
                    mBlk--;
                end
                if (pPend) begin
                    expPh = 1; pBlk = PCOOL;
                end else if (pBlk > 0) begin
                    pBlk--;
                end
                mPend = 0;
                pPend = 0;
            end
            if (mov && !mPend && mBlk == 0) begin
                mPend = 1; mFx = x; mFy = y;
            end
            if (pov && !pPend && pBlk == 0) pPend = 1;
        end
    endtask

    initial begin
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        do_reset(1);

        // Quiet frames, lone draw requests, single and multiple overlaps, cooldown, coincident overlap.
        addv(1,1,0,0,0,0,  0, 0, 0,0,  0, 0);
        addv(0,1,1,0,0,0,100,50, 0,0,  0, 0);
        addv(1,1,0,0,0,0,  0, 0, 0,0,  0, 0);
        addv(0,1,0,1,0,0,100,50, 0,0,  0, 0);
        addv(0,1,0,0,1,0,  3, 3, 0,0,  0, 0);
        addv(0,1,0,0,0,1,  4, 4, 0,0,  0, 0);
        addv(1,1,0,0,0,0,  0, 0, 0,0,  0, 0);
        addv(0,1,1,1,0,0,100,50, 0,0,  0, 0);
        addv(0,1,0,0,0,0,  0, 0, 0,0,  0, 0);
        addv(1,1,0,0,0,0,  0, 0, 1,0,100,50);
        addv(0,1,0,0,0,0,  0, 0, 0,0,100,50);
        addv(0,1,1,1,0,0,  7, 7, 0,0,100,50);
        addv(1,1,0,0,0,0,  0, 0, 0,0,100,50);
        addv(0,1,1,1,0,0,  8, 8, 0,0,100,50);
        addv(1,1,0,0,0,0,  0, 0, 0,0,100,50);
        addv(0,1,1,1,0,0,100,60, 0,0,100,50);
        addv(0,1,1,1,0,0,104,60, 0,0,100,50);
        addv(0,1,1,1,0,0,100,61, 0,0,100,50);
        addv(1,1,0,0,0,0,  0, 0, 1,0,100,60);
        addv(0,1,0,0,0,0,  0, 0, 0,0,100,60);
        addv(1,1,0,0,0,0,  0, 0, 0,0,100,60);
        addv(1,1,1,1,0,0,  5, 6, 0,0,100,60);
        addv(0,1,0,0,0,0,  0, 0, 0,0,100,60);
        addv(1,1,0,0,0,0,  0, 0, 1,0,  5, 6);
        addv(0,1,0,0,0,0,  0, 0, 0,0,  5, 6);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].sof, vecs[i].en, vecs[i].mis, vecs[i].mon, vecs[i].bmb, vecs[i].ply,
                  vecs[i].x, vecs[i].y);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].emh, vecs[i].eph, vecs[i].ehx, vecs[i].ehy);
        end

        // Both channels in one frame, then player invulnerability for 60 frames.
        do_reset(0);
        drive(1, 1, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 1, 1, 1, 1, 30, 40); tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0); tick();
        chk_all("both", 1, 1, 30, 40);
        drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
        chk_all("both_after", 0, 0, 30, 40);
        for (int f = 1; f <= PCOOL; f++) begin
            drive(0, 1, 0, 0, 1, 1, f, f); tick();
            drive(1, 1, 0, 0, 0, 0, 0, 0); tick();
            chk($sformatf("pcool_f%0d", f), {31'd0, playerHit}, 0);
        end
        drive(0, 1, 0, 0, 1, 1, 0, 0); tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0); tick();
        chk("pcool_f61", {31'd0, playerHit}, 1);
        drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
        chk("pcool_f61_once", {31'd0, playerHit}, 0);

        // Enable drop discards a pending event and clears cooldowns; hitX/hitY hold.
        drive(0, 1, 1, 1, 0, 0, 9, 9); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk_all("en_low", 0, 0, 30, 40);
        drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0); tick();
        chk_all("en_nopulse", 0, 0, 30, 40);
        drive(0, 1, 1, 1, 1, 1, 12, 13); tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0); tick();
        chk_all("en_clean", 1, 1, 12, 13);

        // Reset in the middle of a frame drops the pending event.
        drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 1, 1, 0, 0, 11, 12); tick();
        #2 resetN = 1'b0;
        #1 chk_all("rst_mid", 0, 0, 0, 0);
        tick();
        resetN = 1'b1;
        drive(1, 1, 0, 0, 0, 0, 0, 0); tick();
        chk_all("rst_nopulse", 0, 0, 0, 0);

        // Randomised frames against the reference model.
        do_reset(0);
        for (int fr = 0; fr < 300; fr++) begin
            int len;
            len = int'($urandom_range(3, 14));
            for (int c = 0; c < len; c++) begin
                bit sof, en, mis, mon, bmb, ply;
                int x, y;
                sof = (c == 0);
                en  = ($urandom_range(0, 199) != 0);
                mis = ($urandom_range(0, 3) == 0);
                mon = ($urandom_range(0, 2) == 0);
                bmb = ($urandom_range(0, 3) == 0);
                ply = ($urandom_range(0, 2) == 0);
                x   = int'($urandom_range(0, 2047));
                y   = int'($urandom_range(0, 2047));
                drive(sof, en, mis, mon, bmb, ply, x, y);
                tick();
                model_step(sof, en, mis & mon, bmb & ply, x, y);
                chk_all($sformatf("rnd_f%0d_c%0d", fr, c), expMh, expPh, expHx, expHy);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
